// File: rtl/rtc_bus_responder_if.sv
// Multiplexed address/data RTC bus between the RTC main controller (master)
// and the RTC chip model (slave).
interface rtc_bus_responder_if;
  logic       cs_n;
  logic       ad_sel;
  logic       wr_n;
  logic       rd_n;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       irq_n;

  modport master (
    output cs_n, ad_sel, wr_n, rd_n, ad_in,
    input  ad_out, ad_oe, irq_n
  );

  modport slave (
    input  cs_n, ad_sel, wr_n, rd_n, ad_in,
    output ad_out, ad_oe, irq_n
  );
endinterface

// File: rtl/rtc_bus_responder.sv
// RTC chip model: registered bus decode, BCD time/date register file and tick divider.
// Optional countdown timer at 0x40-0x43 is built only when RTC_TIMER_EN is defined.
module rtc_bus_responder #(
  parameter int unsigned CLK_DIV = 100000000
) (
  input  logic               clk,
  input  logic               reset,
  rtc_bus_responder_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_e;

  state_e           state_q, state_d;
  logic             cs_n_q, ad_sel_q, wr_n_q, rd_n_q;
  logic [7:0]       ad_in_q;
  logic [7:0]       addr_q, addr_d;
  logic             ad_oe_q, ad_oe_d;
  logic [7:0]       ad_out_q, ad_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [7:0]       sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic [7:0]       day_q, day_d, mon_q, mon_d, year_q, year_d;
  logic             tick, step, inc, wr_commit;
  logic             c_sec, c_min, c_hour, c_day, c_mon;
  logic [8:0]       sec_inc, min_inc, hour_inc, day_inc, mon_inc, year_inc;
  logic [7:0]       month_len, rdata;
  logic [1:0]       leap_mod;
`ifdef RTC_TIMER_EN
  logic             run_q, run_d, irq_q, irq_d;
  logic [7:0]       tsec_q, tsec_d, tmin_q, tmin_d, thour_q, thour_d;
  logic [8:0]       tsec_dec, tmin_dec, thour_dec;
`endif

  // Returns {carry, next}; invalid BCD or at/above max wraps to min with carry.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v,
                                         input logic [7:0] min_v);
    logic [8:0] r;
    if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v >= max_v) r = {1'b1, min_v};
    else if (v[3:0] == 4'd9)                         r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                                             r = {1'b0, v + 8'd1};
    return r;
  endfunction

  // NOTE: every always_comb assigns all of its outputs a default first, so no latch is inferred.
  always_comb begin : tick_div
    tick  = (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_comb begin : bus_fsm
    state_d   = state_q;
    addr_d    = addr_q;
    ad_oe_d   = ad_oe_q;
    ad_out_d  = ad_out_q;
    wr_commit = 1'b0;
    if (cs_n_q) begin
      state_d  = IDLE;
      ad_oe_d  = 1'b0;
      ad_out_d = 8'h00;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Write strobe wins when both strobes are low.
          if (!wr_n_q) state_d = ad_sel_q ? WDATA : ADDR;
          else if (!rd_n_q && ad_sel_q) begin
            state_d  = RDATA;
            ad_oe_d  = 1'b1;
            ad_out_d = rdata;
          end
        end
        ADDR: if (wr_n_q) begin
          addr_d  = ad_in_q;
          state_d = IDLE;
        end
        WDATA: if (wr_n_q) begin
          wr_commit = 1'b1;
          state_d   = IDLE;
        end
        RDATA: if (rd_n_q) begin
          state_d  = IDLE;
          ad_oe_d  = 1'b0;
          ad_out_d = 8'h00;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin : time_chain
    // BCD year mod 4 == (2*tens + units) mod 4.
    leap_mod = {year_q[4], 1'b0} + year_q[1:0];
    case (mon_q)
      8'h02:                      month_len = (leap_mod == 2'd0) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
      default:                    month_len = 8'h31;
    endcase
    sec_inc  = bcd_inc(sec_q,  8'h59, 8'h00);
    min_inc  = bcd_inc(min_q,  8'h59, 8'h00);
    hour_inc = bcd_inc(hour_q, 8'h23, 8'h00);
    day_inc  = bcd_inc(day_q,  month_len, 8'h01);
    mon_inc  = bcd_inc(mon_q,  8'h12, 8'h01);
    year_inc = bcd_inc(year_q, 8'h99, 8'h00);
    // A data write on a tick cycle wins; the whole increment slips one cycle.
    step   = tick | pend_q;
    inc    = step & ~wr_commit;
    pend_d = step & wr_commit;
    c_sec  = inc    & sec_inc[8];
    c_min  = c_sec  & min_inc[8];
    c_hour = c_min  & hour_inc[8];
    c_day  = c_hour & day_inc[8];
    c_mon  = c_day  & mon_inc[8];
    sec_d  = inc    ? sec_inc[7:0]  : sec_q;
    min_d  = c_sec  ? min_inc[7:0]  : min_q;
    hour_d = c_min  ? hour_inc[7:0] : hour_q;
    day_d  = c_hour ? day_inc[7:0]  : day_q;
    mon_d  = c_day  ? mon_inc[7:0]  : mon_q;
    year_d = c_mon  ? year_inc[7:0] : year_q;
    if (wr_commit) begin
      case (addr_q)
        8'h21:   sec_d  = ad_in_q;
        8'h22:   min_d  = ad_in_q;
        8'h23:   hour_d = ad_in_q;
        8'h24:   day_d  = ad_in_q;
        8'h25:   mon_d  = ad_in_q;
        8'h26:   year_d = ad_in_q;
        default: ;
      endcase
    end
  end

  always_comb begin : read_mux
    case (addr_q)
      8'h21:   rdata = sec_q;
      8'h22:   rdata = min_q;
      8'h23:   rdata = hour_q;
      8'h24:   rdata = day_q;
      8'h25:   rdata = mon_q;
      8'h26:   rdata = year_q;
`ifdef RTC_TIMER_EN
      8'h40:   rdata = {7'd0, run_q};
      8'h41:   rdata = tsec_q;
      8'h42:   rdata = tmin_q;
      8'h43:   rdata = thour_q;
`endif
      default: rdata = 8'h00;
    endcase
  end

  // NOTE: the register file is a few flops, not a RAM, so it takes the async reset like all other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_n_q   <= 1'b1;
      ad_sel_q <= 1'b0;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      ad_in_q  <= 8'h00;
      state_q  <= IDLE;
      addr_q   <= 8'h00;
      ad_oe_q  <= 1'b0;
      ad_out_q <= 8'h00;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      sec_q    <= 8'h00;
      min_q    <= 8'h00;
      hour_q   <= 8'h00;
      day_q    <= 8'h01;
      mon_q    <= 8'h01;
      year_q   <= 8'h00;
    end else begin
      cs_n_q   <= bus.cs_n;
      ad_sel_q <= bus.ad_sel;
      wr_n_q   <= bus.wr_n;
      rd_n_q   <= bus.rd_n;
      ad_in_q  <= bus.ad_in;
      state_q  <= state_d;
      addr_q   <= addr_d;
      ad_oe_q  <= ad_oe_d;
      ad_out_q <= ad_out_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hour_q   <= hour_d;
      day_q    <= day_d;
      mon_q    <= mon_d;
      year_q   <= year_d;
    end
  end

  assign bus.ad_out = ad_out_q;
  assign bus.ad_oe  = ad_oe_q;

`ifdef RTC_TIMER_EN
  // Returns {borrow, next}; 00 borrows to max, invalid BCD reloads max.
  function automatic logic [8:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
    logic [8:0] r;
    if (v == 8'h00)                                        r = {1'b1, max_v};
    else if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v > max_v) r = {1'b0, max_v};
    else if (v[3:0] == 4'd0)                               r = {1'b0, v[7:4] - 4'd1, 4'd9};
    else                                                   r = {1'b0, v - 8'd1};
    return r;
  endfunction

  always_comb begin : countdown
    run_d     = run_q;
    irq_d     = irq_q;
    tsec_d    = tsec_q;
    tmin_d    = tmin_q;
    thour_d   = thour_q;
    tsec_dec  = bcd_dec(tsec_q,  8'h59);
    tmin_dec  = bcd_dec(tmin_q,  8'h59);
    thour_dec = bcd_dec(thour_q, 8'h23);
    if (inc && run_q) begin
      if ({thour_q, tmin_q, tsec_q} != 24'h0) begin
        tsec_d = tsec_dec[7:0];
        if (tsec_dec[8]) tmin_d = tmin_dec[7:0];
        if (tsec_dec[8] && tmin_dec[8]) thour_d = thour_dec[7:0];
      end
      if ({thour_d, tmin_d, tsec_d} == 24'h0) begin
        run_d = 1'b0;
        irq_d = 1'b1;
      end
    end
    if (wr_commit) begin
      case (addr_q)
        8'h40: begin
          run_d = ad_in_q[0];
          irq_d = 1'b0;
        end
        8'h41:   tsec_d  = ad_in_q;
        8'h42:   tmin_d  = ad_in_q;
        8'h43:   thour_d = ad_in_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q   <= 1'b0;
      irq_q   <= 1'b0;
      tsec_q  <= 8'h00;
      tmin_q  <= 8'h00;
      thour_q <= 8'h00;
    end else begin
      run_q   <= run_d;
      irq_q   <= irq_d;
      tsec_q  <= tsec_d;
      tmin_q  <= tmin_d;
      thour_q <= thour_d;
    end
  end

  assign bus.irq_n = ~irq_q;
`else
  assign bus.irq_n = 1'b1;
`endif
endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with CLK_DIV=4: one time step every fourth
// clock after reset release, so every expected value below is fixed by cycle position.
module tb_rtc_bus_responder;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

`ifdef RTC_TIMER_EN
  localparam logic [7:0] IRQ_FIRED = 8'h00;
  localparam logic [7:0] THOUR_RD  = 8'h05;
`else
  localparam logic [7:0] IRQ_FIRED = 8'h01;
  localparam logic [7:0] THOUR_RD  = 8'h00;
`endif

  rtc_bus_responder_if bus ();

  rtc_bus_responder #(.CLK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic addr_phase(input logic [7:0] a);
    bus.cs_n   = 1'b0;
    bus.ad_sel = 1'b0;
    bus.ad_in  = a;
    bus.wr_n   = 1'b0;
    cycles(2);
    bus.wr_n   = 1'b1;
    cycles(2);
  endtask

  task automatic data_write(input logic [7:0] d);
    bus.ad_sel = 1'b1;
    bus.ad_in  = d;
    bus.wr_n   = 1'b0;
    cycles(2);
    bus.wr_n   = 1'b1;
    cycles(2);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr_phase(a);
    data_write(d);
  endtask

  // Data is captured from the register as it stands one cycle after rd_n falls.
  task automatic read_data(input string tag, input logic [7:0] exp);
    bus.ad_sel = 1'b1;
    bus.rd_n   = 1'b0;
    cycles(1);
    check({tag, "_oe_early"}, {7'd0, bus.ad_oe}, 8'h00);
    cycles(1);
    check({tag, "_oe"}, {7'd0, bus.ad_oe}, 8'h01);
    check(tag, bus.ad_out, exp);
    bus.rd_n = 1'b1;
    cycles(1);
    check({tag, "_oe_hold"}, {7'd0, bus.ad_oe}, 8'h01);
    cycles(1);
    check({tag, "_oe_drop"}, {7'd0, bus.ad_oe}, 8'h00);
  endtask

  task automatic bus_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr_phase(a);
    read_data(tag, exp);
  endtask

  initial begin
    reset      = 1'b0;
    bus.cs_n   = 1'b1;
    bus.ad_sel = 1'b0;
    bus.wr_n   = 1'b1;
    bus.rd_n   = 1'b1;
    bus.ad_in  = 8'h00;
    cycles(3);
    check("rst_oe",    {7'd0, bus.ad_oe}, 8'h00);
    check("rst_out",   bus.ad_out, 8'h00);
    check("rst_irq_n", {7'd0, bus.irq_n}, 8'h01);
    reset = 1'b1;

    // Cycle 0 here; steps land on cycles 4, 8, 12, ...
    bus_read("sec_rst",  8'h21, 8'h01);
    bus_read("day_rst",  8'h24, 8'h01);
    bus_read("unmapped", 8'h7F, 8'h00);
    check("irq_n_idle", {7'd0, bus.irq_n}, 8'h01);
    bus_write(8'h23, 8'h15);
    bus_read("hour_wr",  8'h23, 8'h15);
    bus_read("mon_rst",  8'h25, 8'h01);
    bus_read("year_rst", 8'h26, 8'h00);
    bus_read("min_rst",  8'h22, 8'h00);

    // Leap-year February rollover: commits land one cycle after a step.
    cycles(1);
    bus_write(8'h26, 8'h24);
    bus_write(8'h25, 8'h02);
    bus_write(8'h24, 8'h28);
    bus_write(8'h23, 8'h23);
    bus_write(8'h22, 8'h59);
    bus_write(8'h21, 8'h59);
    bus_read("leap_sec",  8'h21, 8'h00);
    bus_read("leap_min",  8'h22, 8'h00);
    bus_read("leap_hour", 8'h23, 8'h00);
    bus_read("leap_day",  8'h24, 8'h29);
    bus_read("leap_mon",  8'h25, 8'h02);
    bus_read("leap_year", 8'h26, 8'h24);

    // Non-leap February rollover into March.
    bus_write(8'h26, 8'h23);
    bus_write(8'h24, 8'h28);
    bus_write(8'h23, 8'h23);
    bus_write(8'h22, 8'h59);
    bus_write(8'h21, 8'h59);
    bus_read("nl_sec",  8'h21, 8'h00);
    bus_read("nl_day",  8'h24, 8'h01);
    bus_read("nl_mon",  8'h25, 8'h03);
    bus_read("nl_year", 8'h26, 8'h23);
    bus_read("nl_hour", 8'h23, 8'h00);

    // Sec write commits on the tick cycle: deferred step gives +1, next tick +1 again.
    cycles(3);
    bus_write(8'h21, 8'h30);
    read_data("collide_sec", 8'h31);
    read_data("collide_next", 8'h32);

    // Countdown timer 00:00:02 with RUN=1.
    cycles(1);
    bus_write(8'h41, 8'h02);
    bus_write(8'h42, 8'h00);
    bus_write(8'h43, 8'h00);
    bus_write(8'h40, 8'h01);
    cycles(6);
    check("irq_before_2nd_tick", {7'd0, bus.irq_n}, 8'h01);
    cycles(1);
    check("irq_after_2nd_tick", {7'd0, bus.irq_n}, IRQ_FIRED);
    bus_read("tmr_run_clr", 8'h40, 8'h00);
    bus_write(8'h40, 8'h00);
    check("irq_cleared", {7'd0, bus.irq_n}, 8'h01);
    bus_write(8'h43, 8'h05);
    bus_read("tmr_hour", 8'h43, THOUR_RD);

    // Chip select dropped while in the data-write phase: no commit.
    addr_phase(8'h26);
    bus.ad_sel = 1'b1;
    bus.ad_in  = 8'h77;
    bus.wr_n   = 1'b0;
    cycles(2);
    bus.cs_n = 1'b1;
    cycles(2);
    bus.wr_n = 1'b1;
    cycles(2);
    bus.cs_n = 1'b0;
    cycles(1);
    bus_read("cs_abort_year", 8'h26, 8'h23);

    // Reset asserted mid-cycle during a read.
    addr_phase(8'h25);
    bus.ad_sel = 1'b1;
    bus.rd_n   = 1'b0;
    cycles(2);
    check("rdata_pre_rst_oe", {7'd0, bus.ad_oe}, 8'h01);
    check("rdata_pre_rst",    bus.ad_out, 8'h03);
    #2 reset = 1'b0;
    #1;
    check("async_rst_oe",  {7'd0, bus.ad_oe}, 8'h00);
    check("async_rst_out", bus.ad_out, 8'h00);
    bus.cs_n = 1'b1;
    bus.rd_n = 1'b1;
    cycles(2);
    reset = 1'b1;
    bus_read("post_rst_mon",  8'h25, 8'h01);
    bus_read("post_rst_hour", 8'h23, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
